// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - operand/result bundle for the bit-serial adder/subtractor
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  // requester drives the operation, the engine reports status and result
  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - LSB-first bit-serial add/subtract engine, one bit per clock
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic             sub_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_q;
  logic             busy_q;
  logic             done_q;
  logic             co_q;
  logic             ov_q;
  logic             sum_bit;
  logic             carry_nxt;

  // one full-adder slice on the current operand LSBs
  assign sum_bit   = opa[0] ^ opb[0] ^ carry;
  assign carry_nxt = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

  // control FSM plus datapath registers; subtraction is a + ~b + 1
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      co_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opa    <= bus.a;
            opb    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            sub_q  <= bus.sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_q <= {sum_bit, res_q[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry is the carry into the MSB, carry_nxt the carry out of it
            ov_q   <= carry ^ carry_nxt;
            co_q   <= sub_q ? ~carry_nxt : carry_nxt;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub
module tb_serial_addsub;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // reference: plain integer arithmetic, returns {overflow, carry_out, result}
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, sr;
    int ux, uy, ur;
    logic [W-1:0] r;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux < uy);
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      co = (ur >= (1 << W));
    end
    r  = ur[W-1:0];
    ov = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    return {ov, co, r};
  endfunction

  // issue one op from a negedge and watch a window wide enough to see one done and the return to idle
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic eco, input logic eov);
    int done_cnt, done_at, busy_cnt;
    logic [W-1:0] r_at;
    logic co_at, ov_at, bad_x;
    done_cnt = 0; done_at = 0; busy_cnt = 0; r_at = '0; co_at = 0; ov_at = 0; bad_x = 0;
    bus.start = 1'b1; bus.sub = s; bus.a = x; bus.b = y;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0; bus.a = ~x; bus.b = ~y; bus.sub = ~s;
      end
      if ($isunknown({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow})) bad_x = 1'b1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (done_cnt == 0) begin
          done_at = i; r_at = bus.result; co_at = bus.carry_out; ov_at = bus.overflow;
        end
        done_cnt++;
      end
    end
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " latency"}, done_at, W + 1);
    check({tag, " busy_cycles"}, busy_cnt, W);
    check({tag, " result"}, r_at, er);
    check({tag, " carry_out"}, co_at, eco);
    check({tag, " overflow"}, ov_at, eov);
    check({tag, " hold_result"}, bus.result, er);
    check({tag, " no_x"}, bad_x, 0);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] x, y;
    logic s;
    int done_cnt, last_done, gap_bad, cyc;
    logic [W-1:0] r_first;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;

    vecs[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0};

    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset result", bus.result, 0);
    check("reset carry_out", bus.carry_out, 0);
    check("reset overflow", bus.overflow, 0);
    rst = 1'b0;

    // directed corner vectors
    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].co, vecs[i].ov);

    // random ops against the arithmetic reference
    for (int i = 0; i < 25; i++) begin
      s = 1'($urandom_range(0, 1));
      x = W'($urandom);
      y = W'($urandom);
      m = model(s, x, y);
      run_op($sformatf("rnd%0d", i), s, x, y, m[W-1:0], m[W], m[W+1]);
    end

    // start pulsed with other operands during RUN must be ignored
    done_cnt = 0; r_first = '0;
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h10; bus.b = 8'h20;
    for (int i = 1; i <= 2 * W + 6; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 3) begin bus.start = 1'b1; bus.sub = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; end
      if (i == 5) bus.start = 1'b0;
      if (bus.done) begin
        if (done_cnt == 0) r_first = bus.result;
        done_cnt++;
      end
    end
    check("ignore done_count", done_cnt, 1);
    check("ignore result", r_first, 8'h30);

    // reset three cycles into RUN aborts without a done pulse
    done_cnt = 0;
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'hF0; bus.b = 8'h0F;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.done) done_cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", bus.busy, 0);
    check("abort result", bus.result, 0);
    check("abort done", bus.done, 0);
    check("abort early_done", done_cnt, 0);
    rst = 1'b0;
    run_op("after_rst", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // start held high: ops every W+2 cycles, new operands loaded on each done
    done_cnt = 0; last_done = 0; gap_bad = 0; cyc = 0;
    x = W'($urandom); y = W'($urandom);
    m = model(1'b0, x, y);
    exp_q.push_back(m[W-1:0]);
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = x; bus.b = y;
    while (done_cnt < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (done_cnt > 0 && cyc - last_done != W + 2) gap_bad++;
        last_done = cyc;
        done_cnt++;
        got = exp_q.pop_front();
        check($sformatf("b2b result%0d", done_cnt), bus.result, got);
        x = W'($urandom); y = W'($urandom);
        m = model(1'b0, x, y);
        exp_q.push_back(m[W-1:0]);
        bus.a = x; bus.b = y;
      end
    end
    bus.start = 1'b0;
    check("b2b done_count", done_cnt, 4);
    check("b2b period", gap_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
